// File: rtl/shift_pkg.sv
// shift_pkg: shared types and constants for shift_stage and shifter
package shift_pkg;
    localparam int DEFAULT_AMT_W = 8;
    localparam int SHIFT_W       = 32;

    typedef enum logic [1:0] {SH_LSL, SH_LSR, SH_ASR, SH_ROR} sh_type_e;

    typedef struct packed {
        logic [SHIFT_W-1:0] data;
        logic               cout;
    } shift_res_t;
endpackage

// File: rtl/shifter.sv
// shifter: combinational LSL/LSR/ASR barrel shifter for amounts 0..WIDTH-1
//   data_i  operand
//   shamt_i shift amount (log2(WIDTH) bits)
//   type_i  SH_LSL / SH_LSR / SH_ASR (anything else shifts right logically)
//   data_o  shifted result
module shifter
    import shift_pkg::*;
#(
    parameter int WIDTH = SHIFT_W,
    localparam int SHW  = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] data_i,
    input  logic [SHW-1:0]   shamt_i,
    input  sh_type_e         type_i,
    output logic [WIDTH-1:0] data_o
);
    logic [WIDTH-1:0] asr;

    // Kept in its own assignment so the signed context survives the mux below.
    assign asr = $signed(data_i) >>> shamt_i;

    always_comb data_o = type_i == SH_LSL ? data_i << shamt_i :
                         type_i == SH_ASR ? asr : data_i >> shamt_i;
endmodule

// File: rtl/shift_stage.sv
// shift_stage: registered shift stage with ARM-style amount saturation, carry-out and skid buffer
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid/in_ready    input handshake; in_ready is registered (skid empty)
//   in_data, in_amt      operand and 0..2^AMT_W-1 shift amount
//   in_type              00 LSL, 01 LSR, 10 ASR, 11 ROR or pass-through
//   in_cin               carry passed through when the amount is zero
//   out_valid/out_ready  output handshake
//   out_data, out_cout   registered result and carry-out
// Macro SHIFT_STAGE_ROR_EN: when defined type 11 rotates right, otherwise it passes through.
// WIDTH must equal shift_pkg::SHIFT_W since both registers use shift_res_t.
module shift_stage
    import shift_pkg::*;
#(
    parameter int WIDTH = SHIFT_W,
    parameter int AMT_W = DEFAULT_AMT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [AMT_W-1:0] in_amt,
    input  logic [1:0]       in_type,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_cout
);
    localparam int SHW = $clog2(WIDTH);
    localparam logic [AMT_W:0] W_AMT = (AMT_W+1)'(WIDTH);

    sh_type_e         typ;
    logic [SHW-1:0]   lo, neg_lo, dec_lo;
    logic [WIDTH-1:0] sh_data;
    logic             zero, ge_w, gt_w, msb, accept;
    shift_res_t       res, out_q, out_d, skid_q, skid_d;
    logic             out_valid_q, out_valid_d, skid_valid_q, skid_valid_d;

    assign typ    = sh_type_e'(in_type);
    assign lo     = in_amt[SHW-1:0];
    // Modulo WIDTH these give W-n and n-1; at n==WIDTH they wrap to bit 0 and bit W-1,
    // which are exactly the saturated LSL and LSR carry bits.
    assign neg_lo = -lo;
    assign dec_lo = lo - SHW'(1);
    assign zero   = in_amt == '0;
    assign ge_w   = {1'b0, in_amt} >= W_AMT;
    assign gt_w   = {1'b0, in_amt} > W_AMT;
    assign msb    = in_data[WIDTH-1];
    assign accept = in_valid && in_ready;

    shifter #(.WIDTH(WIDTH)) u_shifter (
        .data_i (in_data),
        .shamt_i(lo),
        .type_i (typ),
        .data_o (sh_data)
    );

`ifdef SHIFT_STAGE_ROR_EN
    logic [WIDTH-1:0] rot;

    // With lo==0 both terms equal in_data, giving the r=0 case for free.
    assign rot = (in_data >> lo) | (in_data << neg_lo);
`endif

    always_comb begin
        res.data = in_data;
        res.cout = in_cin;
        if (!zero) begin
            case (typ)
                SH_LSL: begin
                    res.data = ge_w ? '0 : sh_data;
                    res.cout = !gt_w && in_data[neg_lo];
                end
                SH_LSR: begin
                    res.data = ge_w ? '0 : sh_data;
                    res.cout = !gt_w && in_data[dec_lo];
                end
                SH_ASR: begin
                    res.data = ge_w ? {WIDTH{msb}} : sh_data;
                    res.cout = ge_w ? msb : in_data[dec_lo];
                end
`ifdef SHIFT_STAGE_ROR_EN
                SH_ROR: begin
                    res.data = rot;
                    res.cout = rot[WIDTH-1];
                end
`endif
                default: ;
            endcase
        end
    end

    // The skid only fills while the output stalls, and in_ready is low while it is full,
    // so a skid move and a new accept never coincide.
    always_comb begin
        out_d        = out_q;
        out_valid_d  = out_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        if (!out_valid_q || out_ready) begin
            out_valid_d = skid_valid_q || accept;
            if (skid_valid_q) begin
                out_d        = skid_q;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                out_d = res;
            end
        end else if (accept) begin
            skid_d       = res;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q        <= '0;
            out_valid_q  <= 1'b0;
            skid_q       <= '0;
            skid_valid_q <= 1'b0;
        end else begin
            out_q        <= out_d;
            out_valid_q  <= out_valid_d;
            skid_q       <= skid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    assign in_ready  = !skid_valid_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_q.data;
    assign out_cout  = out_q.cout;
endmodule

// File: tb/tb_shift_stage.sv
// tb_shift_stage: directed and randomized checks of shift_stage against a queue-based reference
module tb_shift_stage;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic [7:0]  in_amt = '0;
    logic [1:0]  in_type = '0;
    logic        in_cin = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_data;
    logic        out_cout;

    int errors = 0;
    int checks = 0;
    logic [32:0] mq[$];

    shift_stage #(.WIDTH(32), .AMT_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_amt(in_amt), .in_type(in_type), .in_cin(in_cin),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_cout(out_cout)
    );

    always #5 clk = ~clk;

    // Reference result {data, cout} straight from the shift rules.
    function automatic logic [32:0] model(logic [31:0] d, int n, logic [1:0] t, logic c);
        logic [31:0] rot;
        int r;
        if (n == 0) return {d, c};
        case (t)
            2'd0: begin
                if (n < 32) return {d << n, d[32-n]};
                if (n == 32) return {32'h0, d[0]};
                return 33'h0;
            end
            2'd1: begin
                if (n < 32) return {d >> n, d[n-1]};
                if (n == 32) return {32'h0, d[31]};
                return 33'h0;
            end
            2'd2: begin
                if (n < 32) return {32'($signed(d) >>> n), d[n-1]};
                return {{32{d[31]}}, d[31]};
            end
            default: begin
`ifdef SHIFT_STAGE_ROR_EN
                r = n % 32;
                if (r == 0) return {d, d[31]};
                rot = (d >> r) | (d << (32 - r));
                return {rot, rot[31]};
`else
                r = 0;
                rot = d;
                return {rot, c};
`endif
            end
        endcase
    endfunction

    task automatic check(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, got, exp);
        end
    endtask

    // Reference FIFO: up to two beats held, in_ready low only when two are held.
    initial forever begin
        bit pop, rdy;
        @(posedge clk or negedge rst_n);
        if (!rst_n) mq.delete();
        else begin
            pop = mq.size() > 0 && out_ready;
            rdy = mq.size() < 2;
            if (pop) void'(mq.pop_front());
            if (in_valid && rdy) mq.push_back(model(in_data, int'(in_amt), in_type, in_cin));
        end
    end

    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            check("cmp in_ready", 32'(in_ready), 32'(mq.size() < 2));
            check("cmp out_valid", 32'(out_valid), 32'(mq.size() > 0));
            if (mq.size() > 0) begin
                check("cmp out_data", out_data, mq[0][32:1]);
                check("cmp out_cout", 32'(out_cout), 32'(mq[0][0]));
            end
        end
    end

    task automatic send(logic [31:0] d, logic [7:0] a, logic [1:0] t, logic c);
        @(negedge clk);
        #1;
        in_valid = 1'b1;
        in_data  = d;
        in_amt   = a;
        in_type  = t;
        in_cin   = c;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic expect_out(string name, logic [31:0] ed, logic ec);
        @(negedge clk);
        check({name, " valid"}, 32'(out_valid), 32'd1);
        check({name, " data"}, out_data, ed);
        check({name, " cout"}, 32'(out_cout), 32'(ec));
    endtask

    initial begin
        int b[6] = '{0, 1, 31, 32, 33, 255};
        #12;
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset in_ready", 32'(in_ready), 32'd1);
        check("reset out_data", out_data, 32'h0);
        check("reset out_cout", 32'(out_cout), 32'd0);
        @(negedge clk);
        #1 rst_n = 1'b1;

        send(32'h00000001, 8'd4, 2'd0, 1'b0);
        expect_out("lsl4", 32'h00000010, 1'b0);
        @(negedge clk);
        check("lsl4 one beat", 32'(out_valid), 32'd0);
        send(32'h80000000, 8'd32, 2'd1, 1'b0);
        expect_out("lsr32", 32'h00000000, 1'b1);
        send(32'h80000000, 8'd40, 2'd2, 1'b0);
        expect_out("asr40", 32'hFFFFFFFF, 1'b1);
        send(32'h00000003, 8'd33, 2'd0, 1'b1);
        expect_out("lsl33", 32'h00000000, 1'b0);
        send(32'h12345678, 8'd0, 2'd2, 1'b1);
        expect_out("asr0", 32'h12345678, 1'b1);
`ifdef SHIFT_STAGE_ROR_EN
        send(32'h000000F1, 8'd4, 2'd3, 1'b1);
        expect_out("ror4", 32'h1000000F, 1'b0);
        send(32'h000000F1, 8'd32, 2'd3, 1'b1);
        expect_out("ror32", 32'h000000F1, 1'b0);
`else
        send(32'h000000F1, 8'd4, 2'd3, 1'b1);
        expect_out("pass4", 32'h000000F1, 1'b1);
        send(32'h000000F1, 8'd32, 2'd3, 1'b1);
        expect_out("pass32", 32'h000000F1, 1'b1);
`endif

        // Backpressure: A to output, B to skid, C held off until space frees.
        @(negedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_amt    = 8'd1;
        in_type   = 2'd0;
        in_cin    = 1'b0;
        in_data   = 32'h11;
        @(posedge clk);
        #1 in_data = 32'h22;
        @(posedge clk);
        #1 in_data = 32'h33;
        @(negedge clk);
        check("bp full in_ready", 32'(in_ready), 32'd0);
        check("bp A held", out_data, 32'h22);
        @(negedge clk);
        check("bp stall in_ready", 32'(in_ready), 32'd0);
        check("bp A stable", out_data, 32'h22);
        #1 out_ready = 1'b1;
        @(negedge clk);
        check("bp B", out_data, 32'h44);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        check("bp C", out_data, 32'h66);
        check("bp C valid", 32'(out_valid), 32'd1);
        @(negedge clk);
        check("bp drained", 32'(out_valid), 32'd0);

        // Asynchronous reset with both registers full.
        @(negedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_amt    = 8'd0;
        in_data   = 32'h5;
        @(posedge clk);
        #1 in_data = 32'h6;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        check("pre-rst in_ready", 32'(in_ready), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("async rst out_valid", 32'(out_valid), 32'd0);
        check("async rst in_ready", 32'(in_ready), 32'd1);
        check("async rst out_data", out_data, 32'h0);
        check("async rst out_cout", 32'(out_cout), 32'd0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        send(32'h00000001, 8'd4, 2'd0, 1'b0);
        expect_out("post-rst", 32'h00000010, 1'b0);

        for (int i = 0; i < 3000; i++) begin
            int p;
            @(negedge clk);
            #1;
            p = int'($urandom_range(0, 9));
            in_valid  = $urandom_range(0, 3) != 0;
            out_ready = $urandom_range(0, 3) != 0;
            in_data   = $urandom_range(0, 4) == 0 ? 32'h80000000 | 32'($urandom_range(0, 255)) : $urandom;
            in_amt    = p < 6 ? 8'(b[p]) : 8'($urandom_range(0, 255));
            in_type   = 2'($urandom_range(0, 3));
            in_cin    = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
